// File: rtl/game_timer_display_if.sv
// Signal bundle between the game-control logic and the timer/display block.
// The master side drives game control; the slave side is the timer itself.
interface game_timer_display_if #(
    parameter int DIGITS = 8
);
    logic                  start;
    logic                  over;
    logic                  dir;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  blank_lz;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;
    logic                  expired;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start, over, dir, load, load_val, blank_lz,
        input  seg, an, expired, bcd_out
    );

    modport slave (
        input  start, over, dir, load, load_val, blank_lz,
        output seg, an, expired, bcd_out
    );
endinterface

// File: rtl/game_timer_display.sv
// Native-BCD game timer (up/down with saturation) driving a multiplexed,
// common-anode 7-segment digit array scanned once per clk_1000 cycle.
module game_timer_display #(
    parameter int DIGITS   = 8,
    parameter int TICK_DIV = 1000
) (
    input  logic                 clk_1000,
    input  logic                 rst,
    game_timer_display_if.slave  bus
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [W-1:0]      time_q;
    logic [W-1:0]      time_d;
    logic [W-1:0]      inc_val;
    logic [W-1:0]      dec_val;
    logic              expired_q;
    logic              expired_d;
    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic              all_nines;
    logic              is_zero;
    logic [IDX_W-1:0]  scan_idx;
    logic [DIGITS-1:0] zero_from;
    logic              lz_run;
    logic [3:0]        digit_sel;
    logic              blank_sel;
    logic [6:0]        seg_d;
    logic [6:0]        seg_q;
    logic [DIGITS-1:0] an_d;
    logic [DIGITS-1:0] an_q;

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Presets are user-facing, so out-of-range nibbles are clamped rather than rejected.
    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        all_nines = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            all_nines = all_nines & (time_q[4*i +: 4] == 4'd9);
        end
    end

    assign is_zero = (time_q == '0);
    assign inc_val = bcd_inc(time_q);
    assign dec_val = bcd_dec(time_q);
    assign tick    = bus.start && !bus.over && !expired_q && (tick_cnt == TICK_LAST);

    // Time update: load beats start=0 beats over beats tick.
    always_comb begin
        time_d    = time_q;
        expired_d = expired_q;
        if (bus.load) begin
            time_d    = bcd_clamp(bus.load_val);
            expired_d = 1'b0;
        end else if (!bus.start) begin
            if (!bus.dir) time_d = '0;
            expired_d = 1'b0;
        end else if (bus.over) begin
            time_d = time_q;
        end else if (tick) begin
            if (!bus.dir) begin
                if (all_nines) expired_d = 1'b1;
                else           time_d    = inc_val;
            end else begin
                if (is_zero) begin
                    expired_d = 1'b1;
                end else begin
                    time_d = dec_val;
                    if (dec_val == '0) expired_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_1000 or posedge rst) begin
        if (rst) begin
            time_q    <= '0;
            expired_q <= 1'b0;
        end else begin
            time_q    <= time_d;
            expired_q <= expired_d;
        end
    end

    always_ff @(posedge clk_1000 or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (bus.load || !bus.start || bus.over) begin
            tick_cnt <= '0;
        end else if (!expired_q) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    // zero_from[i] is set when digits i..DIGITS-1 are all zero.
    always_comb begin
        zero_from = '0;
        lz_run    = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz_run       = lz_run & (time_q[4*i +: 4] == 4'd0);
            zero_from[i] = lz_run;
        end
    end

    always_comb begin
        digit_sel = time_q[4*scan_idx +: 4];
        blank_sel = bus.blank_lz && (scan_idx != '0) && zero_from[scan_idx];
        seg_d     = blank_sel ? 7'b1111111 : seg7(digit_sel);
        an_d      = '1;
        an_d[scan_idx] = 1'b0;
    end

    // seg and an register from the same index so they never disagree.
    always_ff @(posedge clk_1000 or posedge rst) begin
        if (rst) begin
            scan_idx <= '0;
            seg_q    <= 7'b1111111;
            an_q     <= '1;
        end else begin
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.an      = an_q;
    assign bus.expired = expired_q;
    assign bus.bcd_out = time_q;

endmodule

// File: tb/tb_game_timer_display.sv
// Directed bench for game_timer_display: an 8-digit instance at the real
// 1000-cycle second and a 2-digit instance with a short second for saturation.
module tb_game_timer_display;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   pos_count;
    int   low_count [8];

    game_timer_display_if #(.DIGITS(8)) g();
    game_timer_display_if #(.DIGITS(2)) s();

    game_timer_display #(.DIGITS(8), .TICK_DIV(1000)) dut8 (
        .clk_1000 (clk),
        .rst      (rst),
        .bus      (g)
    );

    game_timer_display #(.DIGITS(2), .TICK_DIV(4)) dut2 (
        .clk_1000 (clk),
        .rst      (rst),
        .bus      (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent count of clock edges since reset, used to predict the scan position.
    always @(posedge clk or posedge rst) begin
        if (rst) pos_count <= 0;
        else     pos_count <= pos_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic st, input logic dr, input logic ov,
                                 input logic ld, input logic [31:0] val, input int n);
        g.start    = st;
        g.dir      = dr;
        g.over     = ov;
        g.load     = ld;
        g.load_val = val;
        @(negedge clk);
        g.load = 1'b0;
        if (n > 1) waitCycles(n - 1);
    endtask

    function automatic logic [6:0] expSeg(input int d, input logic blank);
        logic [6:0] r;
        case (d)
            0:       r = 7'b0010010;
            1:       r = 7'b1000000;
            2:       r = 7'b0110000;
            default: r = blank ? 7'b1111111 : 7'b1000000;
        endcase
        return r;
    endfunction

    initial begin
        int idx;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        g.start = 0; g.over = 0; g.dir = 0; g.load = 0; g.load_val = '0; g.blank_lz = 0;
        s.start = 0; s.over = 0; s.dir = 0; s.load = 0; s.load_val = '0; s.blank_lz = 0;
        waitCycles(2);
        checkOutput("rst_bcd", 64'(g.bcd_out), 64'h0);
        checkOutput("rst_an",  64'(g.an),      64'hff);
        checkOutput("rst_seg", 64'(g.seg),     64'h7f);
        checkOutput("rst_exp", 64'(g.expired), 64'h0);
        rst = 1'b0;

        // Counting up at the real one-second rate.
        applyStimulus(1, 0, 0, 0, 32'h0, 999);
        checkOutput("up_999",   64'(g.bcd_out), 64'h0);
        waitCycles(1);
        checkOutput("up_1000",  64'(g.bcd_out), 64'h1);
        waitCycles(11000);
        checkOutput("up_12000", 64'(g.bcd_out), 64'h12);

        g.over = 1'b1;
        waitCycles(1500);
        checkOutput("over_hold", 64'(g.bcd_out), 64'h12);
        g.over = 1'b0;

        // Carry ripple through three digits.
        applyStimulus(1, 0, 0, 1, 32'h999, 1);
        checkOutput("carry_load", 64'(g.bcd_out), 64'h999);
        waitCycles(999);
        checkOutput("carry_pre",  64'(g.bcd_out), 64'h999);
        waitCycles(1);
        checkOutput("carry_bcd",  64'(g.bcd_out), 64'h1000);
        checkOutput("carry_exp",  64'(g.expired), 64'h0);

        // Load lands on the same edge as a tick.
        waitCycles(999);
        applyStimulus(1, 0, 0, 1, 32'h42, 1);
        checkOutput("ldtick_bcd",  64'(g.bcd_out), 64'h42);
        waitCycles(999);
        checkOutput("ldtick_pre",  64'(g.bcd_out), 64'h42);
        waitCycles(1);
        checkOutput("ldtick_next", 64'(g.bcd_out), 64'h43);

        // Counting down to expiry.
        applyStimulus(1, 1, 0, 1, 32'h2, 1);
        waitCycles(1000);
        checkOutput("down_1",     64'(g.bcd_out), 64'h1);
        checkOutput("down_1_exp", 64'(g.expired), 64'h0);
        waitCycles(1000);
        checkOutput("down_0",     64'(g.bcd_out), 64'h0);
        checkOutput("down_0_exp", 64'(g.expired), 64'h1);
        waitCycles(3000);
        checkOutput("down_hold",  64'(g.bcd_out), 64'h0);
        checkOutput("down_hexp",  64'(g.expired), 64'h1);
        g.dir = 1'b0;
        waitCycles(1500);
        checkOutput("dirflip_bcd", 64'(g.bcd_out), 64'h0);
        checkOutput("dirflip_exp", 64'(g.expired), 64'h1);
        applyStimulus(1, 1, 0, 1, 32'h5, 1);
        checkOutput("reload_bcd", 64'(g.bcd_out), 64'h5);
        checkOutput("reload_exp", 64'(g.expired), 64'h0);

        // Stopped: down direction keeps the preset, up direction clears it.
        applyStimulus(0, 1, 0, 0, 32'h0, 5);
        checkOutput("stop_hold",  64'(g.bcd_out), 64'h5);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        checkOutput("stop_clear", 64'(g.bcd_out), 64'h0);

        applyStimulus(0, 1, 0, 1, 32'hF00000A3, 1);
        checkOutput("clamp", 64'(g.bcd_out), 64'h90000093);

        // Scan order and leading-zero blanking on 305.
        g.blank_lz = 1'b1;
        applyStimulus(0, 1, 0, 1, 32'h305, 3);
        for (int d = 0; d < 8; d++) low_count[d] = 0;
        for (int k = 0; k < 16; k++) begin
            idx = (pos_count - 1) % 8;
            checkOutput($sformatf("scan_an%0d", k), 64'(g.an), 64'(8'hff & ~(8'h01 << idx)));
            checkOutput($sformatf("blank_seg%0d", idx), 64'(g.seg), 64'(expSeg(idx, 1'b1)));
            for (int d = 0; d < 8; d++) if (!g.an[d]) low_count[d]++;
            waitCycles(1);
        end
        for (int d = 0; d < 8; d++)
            checkOutput($sformatf("an_count%0d", d), 64'(low_count[d]), 64'd2);
        g.blank_lz = 1'b0;
        waitCycles(2);
        for (int k = 0; k < 8; k++) begin
            idx = (pos_count - 1) % 8;
            checkOutput($sformatf("noblank_seg%0d", idx), 64'(g.seg), 64'(expSeg(idx, 1'b0)));
            waitCycles(1);
        end

        // Two-digit instance: saturation at 99 and a borrow from 10.
        s.load = 1; s.load_val = 8'h99; s.start = 1; s.dir = 0;
        waitCycles(1);
        s.load = 0;
        checkOutput("sat_load", 64'(s.bcd_out), 64'h99);
        waitCycles(3);
        checkOutput("sat_pre",  64'(s.expired), 64'h0);
        waitCycles(1);
        checkOutput("sat_bcd",  64'(s.bcd_out), 64'h99);
        checkOutput("sat_exp",  64'(s.expired), 64'h1);
        waitCycles(8);
        checkOutput("sat_hold", 64'(s.bcd_out), 64'h99);
        s.load = 1; s.load_val = 8'h10; s.dir = 1;
        waitCycles(1);
        s.load = 0;
        checkOutput("borrow_exp0", 64'(s.expired), 64'h0);
        waitCycles(4);
        checkOutput("borrow_bcd",  64'(s.bcd_out), 64'h09);

        // Asynchronous reset in the middle of a clock period.
        applyStimulus(1, 0, 0, 1, 32'h77, 500);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_bcd", 64'(g.bcd_out), 64'h0);
        checkOutput("arst_an",  64'(g.an),      64'hff);
        checkOutput("arst_seg", 64'(g.seg),     64'h7f);
        checkOutput("arst_exp", 64'(g.expired), 64'h0);
        checkOutput("arst_bcd2", 64'(s.bcd_out), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        waitCycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
